// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, D = A - B - Bin, LSB first.
// One difference bit is produced per clock under a start/busy/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  operation request, only sampled while idle
//   a      minuend, captured on an accepted start
//   b      subtrahend, captured on an accepted start
//   bin    borrow-in, captured on an accepted start
//   busy   high while bits are being processed
//   done   one-cycle pulse, d/bout hold the new result
//   d      difference (A - B - Bin) mod 2^WIDTH
//   bout   borrow-out, 1 when A < B + Bin (unsigned)
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              br_q, br_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic              bout_q, bout_d;

   logic              diff;
   logic              br_next;

   // Full-subtractor cell on the current LSBs.
   assign diff    = a_q[0] ^ b_q[0] ^ br_q;
   assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
            res_d = {diff, res_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = br_next;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
               d_d     = {diff, res_q[WIDTH-1:1]};
               bout_d  = br_next;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = (state_q == StShift);
   assign done = (state_q == StDone);
   assign d    = d_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed bench for serial_subtractor at WIDTH=4.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there too.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       bin;
   logic       busy;
   logic       done;
   logic [3:0] d;
   logic       bout;

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(
      .WIDTH(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a    (a),
      .b    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .d    (d),
      .bout (bout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issue one operation from idle; lat counts edges after capture until done is seen.
   // Leaves the DUT back in idle with d/bout still holding the result.
   task automatic do_op(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                        output int lat);
      a     = va;
      b     = vb;
      bin   = vbin;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int dcnt;
      rst_n = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (d !== 4'd0) begin failures++; $display("FAIL reset_d got=%0d exp=0", d); end
      checks++;
      if (bout !== 1'b0) begin failures++; $display("FAIL reset_bout got=%b exp=0", bout); end
      rst_n = 1'b1;
      dcnt  = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) dcnt++;
      end
      checks++;
      if (dcnt !== 0) begin failures++; $display("FAIL idle_no_activity got=%0d exp=0", dcnt); end
   endtask

   task automatic test_basic();
      logic [3:0] va[4]  = '{4'd4, 4'd8, 4'd3, 4'd5};
      logic [3:0] vb[4]  = '{4'd3, 4'd4, 4'd7, 4'd9};
      logic       vc[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [3:0] ed[4]  = '{4'd0, 4'd4, 4'd11, 4'd11};
      logic       eb[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      int lat;
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], vc[i], lat);
         checks++;
         if (lat !== 4) begin
            failures++; $display("FAIL basic%0d_latency got=%0d exp=4", i, lat);
         end
         checks++;
         if (d !== ed[i]) begin
            failures++; $display("FAIL basic%0d_d got=%0d exp=%0d", i, d, ed[i]);
         end
         checks++;
         if (bout !== eb[i]) begin
            failures++; $display("FAIL basic%0d_bout got=%b exp=%b", i, bout, eb[i]);
         end
      end
   endtask

   task automatic test_boundary();
      logic [3:0] va[3]  = '{4'd0, 4'd15, 4'd15};
      logic [3:0] vb[3]  = '{4'd0, 4'd15, 4'd0};
      logic       vc[3]  = '{1'b1, 1'b0, 1'b0};
      logic [3:0] ed[3]  = '{4'd15, 4'd0, 4'd15};
      logic       eb[3]  = '{1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], vc[i], lat);
         checks++;
         if (d !== ed[i]) begin
            failures++; $display("FAIL bound%0d_d got=%0d exp=%0d", i, d, ed[i]);
         end
         checks++;
         if (bout !== eb[i]) begin
            failures++; $display("FAIL bound%0d_bout got=%b exp=%b", i, bout, eb[i]);
         end
      end
   endtask

   task automatic test_handshake();
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at  = -1;
      int overlap  = 0;
      a     = 4'd9;
      b     = 4'd2;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // Operand changes after capture must not leak into the result.
      a     = 4'd0;
      b     = 4'd15;
      bin   = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (busy === 1'b1 && done === 1'b1) overlap++;
         start = (i == 1);
         @(posedge clk); #1;
      end
      start = 1'b0;
      checks++;
      if (busy_cnt !== 4) begin failures++; $display("FAIL hs_busy_cycles got=%0d exp=4", busy_cnt); end
      checks++;
      if (done_cnt !== 1) begin failures++; $display("FAIL hs_done_count got=%0d exp=1", done_cnt); end
      checks++;
      if (done_at !== 4) begin failures++; $display("FAIL hs_done_at got=%0d exp=4", done_at); end
      checks++;
      if (overlap !== 0) begin failures++; $display("FAIL hs_busy_done_overlap got=%0d exp=0", overlap); end
      checks++;
      if (d !== 4'd7) begin failures++; $display("FAIL hs_d got=%0d exp=7", d); end
      checks++;
      if (bout !== 1'b0) begin failures++; $display("FAIL hs_bout got=%b exp=0", bout); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] va[3] = '{4'd6, 4'd1, 4'd12};
      logic [3:0] vb[3] = '{4'd1, 4'd2, 4'd5};
      logic       vc[3] = '{1'b0, 1'b0, 1'b1};
      logic [3:0] ed[3] = '{4'd5, 4'd15, 4'd6};
      logic       eb[3] = '{1'b0, 1'b1, 1'b0};
      int pos[3] = '{-1, -1, -1};
      int n       = 0;
      int hold_bad = 0;
      a     = va[0];
      b     = vb[0];
      bin   = vc[0];
      start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 22; i++) begin
         if (done === 1'b1) begin
            if (n < 3) begin
               pos[n] = i;
               checks++;
               if (d !== ed[n] || bout !== eb[n]) begin
                  failures++;
                  $display("FAIL b2b%0d_result got=%0d/%b exp=%0d/%b", n, d, bout, ed[n], eb[n]);
               end
            end
            n++;
            if (n < 3) begin
               a   = va[n];
               b   = vb[n];
               bin = vc[n];
            end else begin
               start = 1'b0;
            end
         end else if (n > 0 && n <= 3) begin
            if (d !== ed[n-1] || bout !== eb[n-1]) hold_bad++;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      checks++;
      if (n !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", n); end
      checks++;
      if (pos[0] !== 4) begin failures++; $display("FAIL b2b_first_done got=%0d exp=4", pos[0]); end
      checks++;
      if (pos[1] - pos[0] !== 6) begin
         failures++; $display("FAIL b2b_spacing01 got=%0d exp=6", pos[1] - pos[0]);
      end
      checks++;
      if (pos[2] - pos[1] !== 6) begin
         failures++; $display("FAIL b2b_spacing12 got=%0d exp=6", pos[2] - pos[1]);
      end
      checks++;
      if (hold_bad !== 0) begin failures++; $display("FAIL b2b_hold got=%0d exp=0", hold_bad); end
   endtask

   task automatic test_reset_mid();
      int dcnt = 0;
      int lat;
      a     = 4'd10;
      b     = 4'd3;
      bin   = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) dcnt++;
         @(posedge clk); #1;
      end
      checks++;
      if (dcnt !== 0) begin failures++; $display("FAIL rmid_no_done got=%0d exp=0", dcnt); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++;
      if (d !== 4'd0) begin failures++; $display("FAIL rmid_d got=%0d exp=0", d); end
      checks++;
      if (bout !== 1'b0) begin failures++; $display("FAIL rmid_bout got=%b exp=0", bout); end
      do_op(4'd2, 4'd5, 1'b0, lat);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL rmid_latency got=%0d exp=4", lat); end
      checks++;
      if (d !== 4'd13 || bout !== 1'b1) begin
         failures++; $display("FAIL rmid_result got=%0d/%b exp=13/1", d, bout);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      test_reset();
      test_basic();
      test_boundary();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
